// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit billing path. The controller
// uses the same timestamp width, so both sides agree on TIME_W here.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int TIME_W       = 8;
  localparam int DEFAULT_RATE = 2;

endpackage

// File: rtl/parking_exit_billing_if.sv
// Bundle of the queue-write, exit-request and billing-result signals.
// master = controller/gate side, slave = billing block.
interface parking_exit_billing_if
  import parking_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = TIME_W,
  parameter int FEE_W  = 12
);

  logic                     enQ;
  logic [DATA_W-1:0]        data_Q;
  logic                     exit_req;
  logic [DATA_W-1:0]        cur_time;
  logic [FEE_W-1:0]         fee;
  logic [DATA_W-1:0]        duration;
  logic                     fee_valid;
  logic                     busy;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     err_empty;

  modport master (
    output enQ, data_Q, exit_req, cur_time,
    input  fee, duration, fee_valid, busy, count, full, empty, overflow, err_empty
  );

  modport slave (
    input  enQ, data_Q, exit_req, cur_time,
    output fee, duration, fee_valid, busy, count, full, empty, overflow, err_empty
  );

endinterface

// File: rtl/parking_exit_billing_ts_fifo.sv
// In-order timestamp store. The head entry is visible combinationally on
// rd_data; count/full/empty/overflow are registered.
module ts_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             wr_ok;
  logic             rd_ok;

  // Next-state for pointers and occupancy; the full check uses the
  // pre-edge count so a write while full is dropped even during a pop.
  always_comb begin
    wr_ok      = wr_en && (count_q != CNT_W'(DEPTH));
    rd_ok      = rd_en && (count_q != '0);
    wr_ptr_d   = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = wr_en && !wr_ok;
  end

  // Pointer, count and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents after reset are don't-care, so no reset here.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/parking_exit_billing.sv
// Exit-gate billing: pops the oldest entry timestamp on an exit request,
// computes the (wrapping) parked duration and the saturated fee.
module parking_exit_billing
  import parking_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = TIME_W,
  parameter int RATE   = DEFAULT_RATE,
  parameter int FEE_W  = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  parking_exit_billing_if.slave bus
);

  localparam int PROD_W = DATA_W + 32;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] t_in_q, t_in_d;
  logic [DATA_W-1:0] t_out_q, t_out_d;
  logic [DATA_W-1:0] duration_q, duration_d;
  logic [FEE_W-1:0]  fee_q, fee_d;
  logic              fee_valid_q, fee_valid_d;
  logic              busy_q, busy_d;
  logic              err_empty_q, err_empty_d;
  logic              pop;
  logic [PROD_W-1:0] product;

  logic [DATA_W-1:0]      head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_overflow;

  ts_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (bus.enQ),
    .wr_data  (bus.data_Q),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  // Billing sequencer: IDLE -> READ (latch + pop) -> CALC -> DONE (pulse).
  always_comb begin
    state_d     = state_q;
    t_in_d      = t_in_q;
    t_out_d     = t_out_q;
    duration_d  = duration_q;
    fee_d       = fee_q;
    fee_valid_d = 1'b0;
    err_empty_d = 1'b0;
    pop         = 1'b0;
    product     = '0;
    case (state_q)
      IDLE: begin
        if (bus.exit_req) begin
          if (fifo_empty) begin
            err_empty_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        t_in_d  = head;
        t_out_d = bus.cur_time;
        pop     = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        duration_d  = t_out_q - t_in_q;
        product     = PROD_W'(duration_d) * PROD_W'(RATE);
        if (product[PROD_W-1:FEE_W] != '0) begin
          fee_d = '1;
        end else begin
          fee_d = product[FEE_W-1:0];
        end
        fee_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Registered state and outputs; reset aborts any computation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      t_in_q      <= '0;
      t_out_q     <= '0;
      duration_q  <= '0;
      fee_q       <= '0;
      fee_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_in_q      <= t_in_d;
      t_out_q     <= t_out_d;
      duration_q  <= duration_d;
      fee_q       <= fee_d;
      fee_valid_q <= fee_valid_d;
      busy_q      <= busy_d;
      err_empty_q <= err_empty_d;
    end
  end

  assign bus.fee       = fee_q;
  assign bus.duration  = duration_q;
  assign bus.fee_valid = fee_valid_q;
  assign bus.busy      = busy_q;
  assign bus.err_empty = err_empty_q;
  assign bus.count     = fifo_count;
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.overflow  = fifo_overflow;

endmodule

// File: tb/tb_parking_exit_billing.sv
// Bench for parking_exit_billing: table vectors, hand-written corner
// sequences and randomized park/exit traffic against a queue model.
module tb_parking_exit_billing;

  localparam int DEPTH   = 8;
  localparam int DATA_W  = 8;
  localparam int RATE    = 2;
  localparam int FEE_W   = 12;
  localparam int FEE_MAX = (1 << FEE_W) - 1;

  typedef struct {
    logic [7:0] t_in;
    logic [7:0] t_out;
    int         exp_dur;
    int         exp_fee;
  } vec_t;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] model_q[$];
  vec_t vecs[6];

  parking_exit_billing_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FEE_W(FEE_W)) bus ();

  parking_exit_billing #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .RATE   (RATE),
    .FEE_W  (FEE_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against the expected one.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Expected duration/fee from the billing rules.
  function automatic int expDur(input logic [7:0] t_in, input logic [7:0] t_out);
    return (int'(t_out) - int'(t_in) + 256) % 256;
  endfunction

  function automatic int expFee(input int dur);
    int f;
    f = dur * RATE;
    return (f > FEE_MAX) ? FEE_MAX : f;
  endfunction

  // One enQ pulse; checks drop/overflow and occupancy against the model.
  task automatic applyStimulus(input logic [7:0] d);
    int exp_ovf;
    exp_ovf = (model_q.size() == DEPTH) ? 1 : 0;
    bus.enQ    = 1'b1;
    bus.data_Q = d;
    @(negedge clock);
    bus.enQ = 1'b0;
    if (exp_ovf == 0) model_q.push_back(d);
    checkOutput("wr_overflow", int'(bus.overflow), exp_ovf);
    checkOutput("wr_count", int'(bus.count), model_q.size());
    checkOutput("wr_full", int'(bus.full), (model_q.size() == DEPTH) ? 1 : 0);
    checkOutput("wr_empty", int'(bus.empty), (model_q.size() == 0) ? 1 : 0);
  endtask

  // One exit request; expects either err_empty or a billed result.
  task automatic doExit(input logic [7:0] cur);
    int lat;
    int dur;
    logic [7:0] t_in;
    if (model_q.size() == 0) begin
      bus.exit_req = 1'b1;
      bus.cur_time = cur;
      @(negedge clock);
      bus.exit_req = 1'b0;
      checkOutput("exit_err_empty", int'(bus.err_empty), 1);
      checkOutput("exit_err_busy", int'(bus.busy), 0);
      @(negedge clock);
      checkOutput("exit_err_clear", int'(bus.err_empty), 0);
    end else begin
      t_in = model_q.pop_front();
      dur  = expDur(t_in, cur);
      lat  = 0;
      bus.exit_req = 1'b1;
      bus.cur_time = cur;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clock);
        bus.exit_req = 1'b0;
        if (bus.fee_valid) begin
          lat = i;
          break;
        end
      end
      checkOutput("exit_latency", lat, 3);
      checkOutput("exit_duration", int'(bus.duration), dur);
      checkOutput("exit_fee", int'(bus.fee), expFee(dur));
      @(negedge clock);
      checkOutput("exit_fv_pulse", int'(bus.fee_valid), 0);
      checkOutput("exit_busy_done", int'(bus.busy), 0);
      checkOutput("exit_count", int'(bus.count), model_q.size());
    end
  endtask

  initial begin
    int fv_seen;
    int nw;

    vecs[0] = '{8'd20,  8'd50,  30,  60};
    vecs[1] = '{8'd250, 8'd4,   10,  20};
    vecs[2] = '{8'd0,   8'd255, 255, 510};
    vecs[3] = '{8'd100, 8'd100, 0,   0};
    vecs[4] = '{8'd200, 8'd199, 255, 510};
    vecs[5] = '{8'd7,   8'd3,   252, 504};

    bus.enQ      = 1'b0;
    bus.data_Q   = '0;
    bus.exit_req = 1'b0;
    bus.cur_time = '0;
    reset        = 1'b0;

    // Reset then idle.
    repeat (3) @(negedge clock);
    reset = 1'b1;
    checkOutput("rst_empty", int'(bus.empty), 1);
    checkOutput("rst_full", int'(bus.full), 0);
    checkOutput("rst_count", int'(bus.count), 0);
    checkOutput("rst_fee", int'(bus.fee), 0);
    checkOutput("rst_duration", int'(bus.duration), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_overflow", int'(bus.overflow), 0);
    checkOutput("rst_err_empty", int'(bus.err_empty), 0);
    fv_seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.fee_valid) fv_seen++;
    end
    checkOutput("idle_no_fee_valid", fv_seen, 0);

    // Table vectors: single park/exit pairs including wrap-around.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].t_in);
      doExit(vecs[i].t_out);
      checkOutput("tbl_duration", int'(bus.duration), vecs[i].exp_dur);
      checkOutput("tbl_fee", int'(bus.fee), vecs[i].exp_fee);
    end

    // FIFO order, full and dropped write.
    for (int i = 0; i < 8; i++) applyStimulus(8'(10 + i));
    applyStimulus(8'd99);
    @(negedge clock);
    checkOutput("ovf_one_pulse", int'(bus.overflow), 0);
    checkOutput("ovf_full_held", int'(bus.full), 1);

    // Exit while full with a write on the pop edge: write still dropped.
    bus.exit_req = 1'b1;
    bus.cur_time = 8'd100;
    @(negedge clock);
    bus.exit_req = 1'b0;
    checkOutput("full_exit_busy", int'(bus.busy), 1);
    bus.enQ    = 1'b1;
    bus.data_Q = 8'd77;
    @(negedge clock);
    bus.enQ = 1'b0;
    checkOutput("full_pop_ovf", int'(bus.overflow), 1);
    checkOutput("full_pop_count", int'(bus.count), 7);
    @(negedge clock);
    checkOutput("full_pop_fv", int'(bus.fee_valid), 1);
    checkOutput("full_pop_dur", int'(bus.duration), 90);
    void'(model_q.pop_front());
    @(negedge clock);
    for (int i = 1; i < 8; i++) begin
      doExit(8'd100);
      checkOutput("order_dur", int'(bus.duration), 90 - i);
    end
    checkOutput("order_empty", int'(bus.empty), 1);

    // exit while empty, and write into empty on the same edge.
    doExit(8'd1);
    bus.enQ      = 1'b1;
    bus.data_Q   = 8'd42;
    bus.exit_req = 1'b1;
    @(negedge clock);
    bus.enQ      = 1'b0;
    bus.exit_req = 1'b0;
    model_q.push_back(8'd42);
    checkOutput("wr_exit_err", int'(bus.err_empty), 1);
    checkOutput("wr_exit_busy", int'(bus.busy), 0);
    checkOutput("wr_exit_count", int'(bus.count), 1);

    // exit_req held high through the whole computation: one pop only.
    applyStimulus(8'd30);
    bus.exit_req = 1'b1;
    bus.cur_time = 8'd60;
    repeat (3) @(negedge clock);
    checkOutput("hold_fv", int'(bus.fee_valid), 1);
    checkOutput("hold_dur", int'(bus.duration), 18);
    @(negedge clock);
    bus.exit_req = 1'b0;
    void'(model_q.pop_front());
    checkOutput("hold_count", int'(bus.count), 1);
    doExit(8'd45);

    // Reset asserted in CALC aborts without a fee_valid pulse.
    applyStimulus(8'd5);
    bus.exit_req = 1'b1;
    bus.cur_time = 8'd50;
    @(negedge clock);
    bus.exit_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_q.delete();
    #1;
    checkOutput("midrst_count", int'(bus.count), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_empty", int'(bus.empty), 1);
    fv_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.fee_valid) fv_seen++;
    end
    checkOutput("midrst_no_fv", fv_seen, 0);
    reset = 1'b1;
    applyStimulus(8'd60);
    doExit(8'd70);

    // Randomized traffic against the queue model.
    for (int it = 0; it < 60; it++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) applyStimulus(8'($urandom));
      if ($urandom_range(0, 2) != 0) doExit(8'($urandom));
      else @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_exit_billing.md
Name: parking_exit_billing

Overview:
- Receiving end of the controller's queue-write interface (enQ/data_Q). Each enQ pulse stores one 8-bit entry timestamp in an in-order FIFO.
- At the exit gate, an exit request pops the oldest timestamp and computes the parked duration against the current time, then the fee.
- The block sits between the controller's queue output and the exit gate/display logic.

Parameters:
- DEPTH, 8, FIFO entries (power of two, 2..64).
- DATA_W, 8, timestamp width; matches data_Q.
- RATE, 2, fee units charged per time unit.
- FEE_W, 12, fee output width.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset.
- enQ  in  1  write strobe from the controller; one entry per high cycle.
- data_Q  in  DATA_W  entry timestamp, sampled when enQ=1.
- exit_req  in  1  exit request; sampled only in IDLE.
- cur_time  in  DATA_W  current time, sampled in READ.
- fee  out  FEE_W  computed fee; held until the next computation.
- duration  out  DATA_W  computed duration; held until the next computation.
- fee_valid  out  1  one-cycle pulse when fee and duration are updated.
- busy  out  1  high whenever the state is not IDLE.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  one-cycle pulse when a write is dropped.
- err_empty  out  1  one-cycle pulse when exit_req arrives while empty in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and count go to 0; state goes to IDLE.
  - fee, duration, fee_valid, overflow and err_empty go to 0.
  - empty=1, full=0, busy=0.
  - FIFO storage contents are don't-care.
  - Asserting reset mid-computation aborts it with no fee_valid pulse.
- FIFO write:
  - On a rising edge with enQ=1 and count<DEPTH, data_Q is stored at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
  - With enQ=1 and count==DEPTH, the write is dropped and overflow=1 for the next cycle.
  - The full check uses count before any same-cycle pop, so a write while full is dropped even if READ pops on that edge.
- FSM states: IDLE, READ, CALC, DONE.
  - IDLE: if exit_req=1 and empty=0, go to READ. If exit_req=1 and empty=1, pulse err_empty and stay in IDLE.
  - READ: latch head entry into t_in and cur_time into t_out, pop (rd_ptr increments modulo DEPTH, count decrements), go to CALC.
  - CALC: duration_r = (t_out - t_in) mod 2^DATA_W, so wrap-around is intended (e.g. 250 -> 4 gives 10). fee_r = duration_r*RATE, saturated to 2^FEE_W-1. Go to DONE.
  - DONE: fee_valid=1 for exactly this cycle, with fee and duration already showing the new values. Return to IDLE.
- Latency: exit_req sampled at edge E0 gives fee_valid high in the cycle following E2. Back-to-back exits need 4 cycles each.
- exit_req is ignored while busy=1; it is not queued.
- Simultaneous write and pop on one edge: both take effect and count is unchanged.
- Writing into an empty FIFO on the same edge IDLE samples exit_req: empty is evaluated before the write, so err_empty fires.
- count, full and empty are registered and reflect all edges up to the current one.

Decomposition:
- Shared package parking_pkg holds:
  - the state enum (IDLE/READ/CALC/DONE);
  - the TIME_W=8 constant shared with the controller;
  - a default RATE constant.
- One natural sub-module, ts_fifo: parameterised DEPTH/DATA_W storage with pointers, count, full, empty and overflow.
- The billing FSM and arithmetic stay in the top module.

Test Plan:
- Reset then idle: hold reset=0 for 30, release → empty=1, count=0, fee=0, fee_valid never pulses.
- Single park/exit: enQ with data_Q=8'd20, then exit_req with cur_time=8'd50 → duration=30, fee=60, fee_valid one cycle 3 edges after exit_req, count back to 0.
- Wrap-around: store 8'd250, exit at cur_time=8'd4 → duration=10, fee=20.
- FIFO order and full: write 10,11,…,17, then a ninth write of 99 → full=1, overflow pulses once, 99 not stored. Eight exits at cur_time=100 → durations 90…83 in order, then empty=1.
- Error paths: exit_req while empty → err_empty pulse, busy stays 0. exit_req held high during READ/CALC → only one pop.
- Reset mid-operation: store 5, exit_req, assert reset in CALC → no fee_valid, count=0, state IDLE; normal operation resumes after release.
